// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron sequencer: lane geometry, FSM state
// encoding and the signed saturation used when reporting a neuron value.
package nn_pkg;

    localparam int LANES  = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        PMC_IDLE,
        PMC_LOAD,
        PMC_FIRE,
        PMC_WAIT,
        PMC_OUT
    } pmc_state_t;

    // Clamp a sign-extended accumulator value into the signed DATA_W range.
    function automatic logic [DATA_W-1:0] sat_data(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end
        if (v < -32'sd32768) begin
            return 16'h8000;
        end
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/nrn_packer.sv
// Deserialises input-neuron beats into a LANES-wide vector; beat k lands in lane k.
// The lane contents survive a clear, only the beat counter restarts.
module nrn_packer
    import nn_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           accept,
    input  logic [DATA_W-1:0]              data,
    input  logic                           clear,
    output logic                           full,
    output logic [LANES-1:0][DATA_W-1:0]   vector
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam int IDX_W = $clog2(LANES);

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [LANES-1:0][DATA_W-1:0]    vec_q, vec_d;
    logic                            take;

    // full looks ahead: it is already high in the cycle the last beat is taken,
    // so the controller can leave LOAD without a bubble.
    always_comb begin
        take  = accept && (cnt_q < CNT_W'(LANES));
        cnt_d = cnt_q;
        vec_d = vec_q;
        if (take) begin
            vec_d[cnt_q[IDX_W-1:0]] = data;
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (clear) begin
            cnt_d = '0;
        end
        full = (cnt_q == CNT_W'(LANES)) || (take && (cnt_q == CNT_W'(LANES - 1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            vec_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vec_q <= vec_d;
        end
    end

    assign vector = vec_q;

endmodule

// File: rtl/parallel_mult_ctrl.sv
// Sequences one parallel_mult array: gathers 16-lane groups plus a weight word,
// fires the array, accumulates its sums and returns the saturated neuron value.
module parallel_mult_ctrl
    import nn_pkg::*;
#(
    parameter int PM_LAT = 1,
    parameter int ACC_W  = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [7:0]                     group_cnt,
    input  logic                           nrn_in_valid,
    input  logic [DATA_W-1:0]              nrn_in_data,
    output logic                           nrn_in_ready,
    input  logic                           wgt_valid,
    input  logic [DATA_W-1:0]              wgt_data,
    output logic                           wgt_ready,
    output logic [LANES-1:0][DATA_W-1:0]   pm_input_neuron,
    output logic [DATA_W-1:0]              pm_weight_bits,
    output logic                           pm_en,
    input  logic [DATA_W-1:0]              pm_final_out,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    input  logic                           out_ready,
    output logic                           busy,
    output pmc_state_t                     dbg_state
);

    localparam int WAIT_W = (PM_LAT > 1) ? $clog2(PM_LAT) : 1;

    // Handshakes: a beat transfers on a rising edge where valid && ready are both
    // high; ready never depends combinationally on valid, and a producer must hold
    // valid/data until the transfer.
    pmc_state_t                 state_q, state_d;
    logic [7:0]                 groups_q, groups_d;
    logic [WAIT_W-1:0]          wait_q, wait_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [DATA_W-1:0]          wgt_q, wgt_d, out_data_q, out_data_d;
    logic                       wgt_held_q, wgt_held_d, nrn_done_q, nrn_done_d;
    logic                       nrn_rdy_q, nrn_rdy_d, wgt_rdy_q, wgt_rdy_d;
    logic                       pm_en_q, pm_en_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic                       pk_accept, pk_clear, pk_full, wgt_take, last_wait;
    logic signed [31:0]         acc_ext;

    assign pk_accept = nrn_in_valid && nrn_rdy_q;
    assign wgt_take  = wgt_valid && wgt_rdy_q;

    nrn_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .accept (pk_accept),
        .data   (nrn_in_data),
        .clear  (pk_clear),
        .full   (pk_full),
        .vector (pm_input_neuron)
    );

    always_comb begin
        state_d    = state_q;
        groups_d   = groups_q;
        wait_d     = wait_q;
        acc_d      = acc_q;
        wgt_d      = wgt_q;
        wgt_held_d = wgt_held_q;
        out_data_d = out_data_q;
        pk_clear   = 1'b0;
        last_wait  = (wait_q == WAIT_W'(PM_LAT - 1));
        acc_sum    = acc_q + ACC_W'(signed'(pm_final_out));
        acc_ext    = 32'(acc_sum);
        case (state_q)
            PMC_IDLE: begin
                if (start) begin
                    acc_d      = '0;
                    groups_d   = group_cnt;
                    pk_clear   = 1'b1;
                    wgt_held_d = 1'b0;
                    if (group_cnt == 8'd0) begin
                        out_data_d = '0;
                        state_d    = PMC_OUT;
                    end else begin
                        state_d = PMC_LOAD;
                    end
                end
            end
            PMC_LOAD: begin
                if (wgt_take) begin
                    wgt_d      = wgt_data;
                    wgt_held_d = 1'b1;
                end
                if (pk_full && (wgt_held_q || wgt_take)) begin
                    state_d = PMC_FIRE;
                end
            end
            PMC_FIRE: begin
                pk_clear   = 1'b1;
                wgt_held_d = 1'b0;
                wait_d     = '0;
                state_d    = PMC_WAIT;
            end
            PMC_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (last_wait) begin
                    acc_d    = acc_sum;
                    groups_d = groups_q - 8'd1;
                    if (groups_q == 8'd1) begin
                        out_data_d = sat_data(acc_ext);
                        state_d    = PMC_OUT;
                    end else begin
                        state_d = PMC_LOAD;
                    end
                end
            end
            PMC_OUT: begin
                if (out_valid_q && out_ready) begin
                    state_d = PMC_IDLE;
                end
            end
            default: state_d = PMC_IDLE;
        endcase
        nrn_done_d  = pk_full && !pk_clear;
        nrn_rdy_d   = (state_d == PMC_LOAD) && !nrn_done_d;
        wgt_rdy_d   = (state_d == PMC_LOAD) && !wgt_held_d;
        pm_en_d     = (state_d == PMC_FIRE);
        out_valid_d = (state_d == PMC_OUT);
        busy_d      = (state_d != PMC_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PMC_IDLE;
            groups_q    <= '0;
            wait_q      <= '0;
            acc_q       <= '0;
            wgt_q       <= '0;
            wgt_held_q  <= 1'b0;
            nrn_done_q  <= 1'b0;
            out_data_q  <= '0;
            nrn_rdy_q   <= 1'b0;
            wgt_rdy_q   <= 1'b0;
            pm_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            groups_q    <= groups_d;
            wait_q      <= wait_d;
            acc_q       <= acc_d;
            wgt_q       <= wgt_d;
            wgt_held_q  <= wgt_held_d;
            nrn_done_q  <= nrn_done_d;
            out_data_q  <= out_data_d;
            nrn_rdy_q   <= nrn_rdy_d;
            wgt_rdy_q   <= wgt_rdy_d;
            pm_en_q     <= pm_en_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign nrn_in_ready   = nrn_rdy_q;
    assign wgt_ready      = wgt_rdy_q;
    assign pm_weight_bits = wgt_q;
    assign pm_en          = pm_en_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_parallel_mult_ctrl.sv
// Directed bench for parallel_mult_ctrl: drives neuron/weight streams, models the
// array's latency and checks each scenario against hand-computed values.
module tb_parallel_mult_ctrl;
    import nn_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [7:0]             group_cnt;
    logic                   nrn_in_valid;
    logic [15:0]            nrn_in_data;
    logic                   nrn_in_ready;
    logic                   wgt_valid;
    logic [15:0]            wgt_data;
    logic                   wgt_ready;
    logic [15:0][15:0]      pm_input_neuron;
    logic [15:0]            pm_weight_bits;
    logic                   pm_en;
    logic [15:0]            pm_final_out;
    logic                   out_valid;
    logic [15:0]            out_data;
    logic                   out_ready;
    logic                   busy;
    pmc_state_t             dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0]            res_tab [0:7];
    logic [15:0]            wgt_tab [0:7];
    logic [15:0][15:0]      cap_lanes [0:7];
    logic [15:0]            cap_wgt [0:7];
    int                     pm_en_cnt, first_fire_cyc, first_out_cyc, out_cycles;
    logic [15:0]            first_out_data;
    bit                     any_ready, out_unstable, fire_early, job_timeout;

    parallel_mult_ctrl #(.PM_LAT(1), .ACC_W(24)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .group_cnt       (group_cnt),
        .nrn_in_valid    (nrn_in_valid),
        .nrn_in_data     (nrn_in_data),
        .nrn_in_ready    (nrn_in_ready),
        .wgt_valid       (wgt_valid),
        .wgt_data        (wgt_data),
        .wgt_ready       (wgt_ready),
        .pm_input_neuron (pm_input_neuron),
        .pm_weight_bits  (pm_weight_bits),
        .pm_en           (pm_en),
        .pm_final_out    (pm_final_out),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: one output neuron. Cycle 0 is the cycle start is high. Beat k of group g
    // carries g*0x100 + k + 1; the array model returns res_tab[g] one cycle after pm_en.
    task automatic run_job(input logic [7:0] gc, input bit rand_v, input int wdelay,
                           input int stall, input bit start_in_out);
        int  beat = 0;
        int  ngrp = 0;
        int  wg = 0;
        int  since = 0;
        int  out_seen = 0;
        bit  hs = 0;
        pm_en_cnt = 0; first_fire_cyc = -1; first_out_cyc = -1; out_cycles = 0;
        first_out_data = '0; any_ready = 0; out_unstable = 0; fire_early = 0; job_timeout = 0;
        @(posedge clk); #1;
        group_cnt = gc;
        for (int cyc = 0; cyc < 3000 && !hs; cyc++) begin
            start        = (cyc == 0) || (start_in_out && out_cycles > 0);
            nrn_in_valid = (ngrp < int'(gc)) && (rand_v ? ($urandom_range(0, 1) == 1) : 1'b1);
            nrn_in_data  = 16'((ngrp << 8) + beat + 1);
            wgt_valid    = (wg < int'(gc)) && (wdelay < 0 || (wg < ngrp && since >= wdelay));
            wgt_data     = wgt_tab[wg];
            out_ready    = (out_seen >= stall);
            @(negedge clk);
            if (nrn_in_ready || wgt_ready) any_ready = 1;
            if (pm_en) begin
                if (pm_en_cnt == 0) first_fire_cyc = cyc;
                if (wg <= pm_en_cnt || ngrp <= pm_en_cnt) fire_early = 1;
                if (pm_en_cnt < 8) begin
                    cap_lanes[pm_en_cnt] = pm_input_neuron;
                    cap_wgt[pm_en_cnt]   = pm_weight_bits;
                    pm_final_out         = res_tab[pm_en_cnt];
                end
                pm_en_cnt++;
            end
            if (out_valid) begin
                if (out_cycles == 0) begin
                    first_out_cyc  = cyc;
                    first_out_data = out_data;
                end else if (out_data !== first_out_data) begin
                    out_unstable = 1;
                end
                out_cycles++;
                out_seen++;
                if (out_ready) hs = 1;
            end
            if (wgt_valid && wgt_ready) wg++;
            if (nrn_in_valid && nrn_in_ready) begin
                beat++;
                if (beat == 16) begin
                    beat = 0;
                    ngrp++;
                    since = 0;
                end
            end else begin
                since++;
            end
            @(posedge clk); #1;
        end
        if (!hs) job_timeout = 1;
        start = 0; nrn_in_valid = 0; wgt_valid = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (nrn_in_ready !== 1'b0) $display("FAIL reset_nrn_ready: got %b expected 0", nrn_in_ready); else n_pass++;
        n_checks++; if (wgt_ready !== 1'b0) $display("FAIL reset_wgt_ready: got %b expected 0", wgt_ready); else n_pass++;
        n_checks++; if (pm_en !== 1'b0) $display("FAIL reset_pm_en: got %b expected 0", pm_en); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (pm_input_neuron !== '0) $display("FAIL reset_lanes: got %h expected 0", pm_input_neuron); else n_pass++;
        n_checks++; if (pm_weight_bits !== 16'h0) $display("FAIL reset_wgt_bits: got %h expected 0000", pm_weight_bits); else n_pass++;
        n_checks++; if (out_data !== 16'h0) $display("FAIL reset_out_data: got %h expected 0000", out_data); else n_pass++;
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_packing();
        logic [15:0] exp_v;
        wgt_tab[0] = 16'hA5A5; res_tab[0] = 16'h0123;
        run_job(8'd1, 1'b0, -1, 0, 1'b0);
        n_checks++; if (job_timeout) $display("FAIL pack_timeout: got timeout expected handshake"); else n_pass++;
        n_checks++; if (first_fire_cyc != 17) $display("FAIL pack_fire_cycle: got %0d expected 17", first_fire_cyc); else n_pass++;
        n_checks++; if (pm_en_cnt != 1) $display("FAIL pack_pm_en_count: got %0d expected 1", pm_en_cnt); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            exp_v = 16'(k + 1);
            n_checks++; if (cap_lanes[0][k] !== exp_v) $display("FAIL pack_lane%0d: got %h expected %h", k, cap_lanes[0][k], exp_v); else n_pass++;
        end
        n_checks++; if (cap_wgt[0] !== 16'hA5A5) $display("FAIL pack_weight: got %h expected a5a5", cap_wgt[0]); else n_pass++;
        n_checks++; if (first_out_cyc != 19) $display("FAIL pack_out_cycle: got %0d expected 19", first_out_cyc); else n_pass++;
        n_checks++; if (first_out_data !== 16'h0123) $display("FAIL pack_out_data: got %h expected 0123", first_out_data); else n_pass++;
    endtask

    task automatic test_accumulate();
        wgt_tab[0] = 16'h1111; wgt_tab[1] = 16'h2222; wgt_tab[2] = 16'h3333;
        res_tab[0] = 16'h0100; res_tab[1] = 16'hFF00; res_tab[2] = 16'h0005;
        run_job(8'd3, 1'b0, -1, 0, 1'b0);
        n_checks++; if (job_timeout) $display("FAIL acc_timeout: got timeout expected handshake"); else n_pass++;
        n_checks++; if (first_out_data !== 16'h0005) $display("FAIL acc_out_data: got %h expected 0005", first_out_data); else n_pass++;
        n_checks++; if (pm_en_cnt != 3) $display("FAIL acc_pm_en_count: got %0d expected 3", pm_en_cnt); else n_pass++;
        n_checks++; if (first_out_cyc != 55) $display("FAIL acc_out_cycle: got %0d expected 55", first_out_cyc); else n_pass++;
        n_checks++; if (cap_wgt[2] !== 16'h3333) $display("FAIL acc_weight2: got %h expected 3333", cap_wgt[2]); else n_pass++;
    endtask

    task automatic test_saturation();
        for (int g = 0; g < 4; g++) res_tab[g] = 16'h7000;
        run_job(8'd4, 1'b0, -1, 0, 1'b0);
        n_checks++; if (first_out_data !== 16'h7FFF) $display("FAIL sat_pos: got %h expected 7fff", first_out_data); else n_pass++;
        n_checks++; if (pm_en_cnt != 4) $display("FAIL sat_pos_pm_en_count: got %0d expected 4", pm_en_cnt); else n_pass++;
        for (int g = 0; g < 4; g++) res_tab[g] = 16'h8000;
        run_job(8'd4, 1'b0, -1, 0, 1'b0);
        n_checks++; if (first_out_data !== 16'h8000) $display("FAIL sat_neg: got %h expected 8000", first_out_data); else n_pass++;
        n_checks++; if (job_timeout) $display("FAIL sat_timeout: got timeout expected handshake"); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_v;
        wgt_tab[0] = 16'h3C3C; wgt_tab[1] = 16'h0FF0;
        res_tab[0] = 16'h0010; res_tab[1] = 16'h0020;
        run_job(8'd2, 1'b1, 3, 5, 1'b1);
        n_checks++; if (job_timeout) $display("FAIL bp_timeout: got timeout expected handshake"); else n_pass++;
        n_checks++; if (fire_early) $display("FAIL bp_fire_before_weight: got early pm_en expected none"); else n_pass++;
        n_checks++; if (pm_en_cnt != 2) $display("FAIL bp_pm_en_count: got %0d expected 2", pm_en_cnt); else n_pass++;
        for (int k = 0; k < 16; k += 5) begin
            exp_v = 16'(16'h0101 + k);
            n_checks++; if (cap_lanes[1][k] !== exp_v) $display("FAIL bp_g1_lane%0d: got %h expected %h", k, cap_lanes[1][k], exp_v); else n_pass++;
        end
        n_checks++; if (cap_wgt[1] !== 16'h0FF0) $display("FAIL bp_weight1: got %h expected 0ff0", cap_wgt[1]); else n_pass++;
        n_checks++; if (first_out_data !== 16'h0030) $display("FAIL bp_out_data: got %h expected 0030", first_out_data); else n_pass++;
        n_checks++; if (out_unstable) $display("FAIL bp_out_stable: got changing out_data expected stable"); else n_pass++;
        n_checks++; if (out_cycles != 6) $display("FAIL bp_out_valid_cycles: got %0d expected 6", out_cycles); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_start_ignored_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_out_valid_drop: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_zero_groups();
        run_job(8'd0, 1'b0, -1, 0, 1'b0);
        n_checks++; if (first_out_cyc != 1) $display("FAIL zero_out_cycle: got %0d expected 1", first_out_cyc); else n_pass++;
        n_checks++; if (first_out_data !== 16'h0000) $display("FAIL zero_out_data: got %h expected 0000", first_out_data); else n_pass++;
        n_checks++; if (any_ready) $display("FAIL zero_ready: got ready asserted expected none"); else n_pass++;
        n_checks++; if (pm_en_cnt != 0) $display("FAIL zero_pm_en_count: got %0d expected 0", pm_en_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int beats = 0;
        @(posedge clk); #1;
        start = 1; group_cnt = 8'd1;
        nrn_in_valid = 1; nrn_in_data = 16'h0AA0; wgt_valid = 1; wgt_data = 16'h1234;
        for (int c = 0; c < 40 && beats < 7; c++) begin
            @(negedge clk);
            if (nrn_in_ready) beats++;
            @(posedge clk); #1;
            start = 0;
            nrn_in_data = 16'h0AA0 + 16'(beats);
        end
        n_checks++; if (beats != 7) $display("FAIL rml_beats: got %0d expected 7", beats); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rml_busy_before: got %b expected 1", busy); else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rml_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (nrn_in_ready !== 1'b0) $display("FAIL rml_nrn_ready: got %b expected 0", nrn_in_ready); else n_pass++;
        n_checks++; if (wgt_ready !== 1'b0) $display("FAIL rml_wgt_ready: got %b expected 0", wgt_ready); else n_pass++;
        n_checks++; if (pm_input_neuron !== '0) $display("FAIL rml_lanes: got %h expected 0", pm_input_neuron); else n_pass++;
        n_checks++; if (pm_weight_bits !== 16'h0) $display("FAIL rml_wgt_bits: got %h expected 0000", pm_weight_bits); else n_pass++;
        nrn_in_valid = 0; wgt_valid = 0;
        @(posedge clk); #1; rst = 1'b1;
        wgt_tab[0] = 16'h5A5A; res_tab[0] = 16'h0042;
        run_job(8'd1, 1'b0, -1, 0, 1'b0);
        n_checks++; if (first_fire_cyc != 17) $display("FAIL rml_fire_cycle: got %0d expected 17", first_fire_cyc); else n_pass++;
        n_checks++; if (cap_lanes[0][0] !== 16'h0001) $display("FAIL rml_lane0: got %h expected 0001", cap_lanes[0][0]); else n_pass++;
        n_checks++; if (cap_lanes[0][15] !== 16'h0010) $display("FAIL rml_lane15: got %h expected 0010", cap_lanes[0][15]); else n_pass++;
        n_checks++; if (first_out_data !== 16'h0042) $display("FAIL rml_out_data: got %h expected 0042", first_out_data); else n_pass++;
    endtask

    initial begin
        rst = 1'b0; start = 0; group_cnt = '0;
        nrn_in_valid = 0; nrn_in_data = '0; wgt_valid = 0; wgt_data = '0;
        pm_final_out = '0; out_ready = 0;
        test_reset();
        test_packing();
        test_accumulate();
        test_saturation();
        test_backpressure();
        test_zero_groups();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/parallel_mult_ctrl.md
# parallel_mult_ctrl

Sequencer that drives one `parallel_mult` array to compute a full output neuron. It deserialises a stream of 16-bit input neurons into 16-lane vectors and pairs each vector with one 16-bit binary-weight word. It fires the array once per 16-lane group and accumulates the array's `FinalOut` results over a programmable number of groups. It then presents the saturated neuron value on a valid/ready output. It sits between the activation/weight memory streamers and the multiplier/adder-tree array.

## Interface
- `PM_LAT`, default 1: cycles from the `pm_en` cycle until `pm_final_out` is valid.
- `ACC_W`, default 24: width of the signed accumulator.

- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin one output neuron; sampled only in IDLE.
- `group_cnt` in 8: number of 16-lane groups; sampled with `start`.
- `nrn_in_valid` in 1, `nrn_in_data` in 16, `nrn_in_ready` out 1: input neuron stream.
- `wgt_valid` in 1, `wgt_data` in 16, `wgt_ready` out 1: one weight word per group.
- `pm_input_neuron` out 16x16: lane vector to the array.
- `pm_weight_bits` out 16: weight word to the array.
- `pm_en` out 1: array enable, one-cycle pulse.
- `pm_final_out` in 16: signed array sum.
- `out_valid` out 1, `out_data` out 16, `out_ready` in 1: result handshake.
- `busy` out 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE: go to LOAD on `start`, or to OUT if `group_cnt` = 0.
  - LOAD: go to FIRE once 16 neurons are accepted and a weight is captured.
  - FIRE: one cycle; `pm_en` = 1; go to WAIT.
  - WAIT: PM_LAT cycles; on the last cycle, add `pm_final_out` to the accumulator and decrement the remaining-group count; go to LOAD if groups remain, else OUT.
  - OUT: hold until `out_valid && out_ready`; then go to IDLE.
- Neuron beat k of a group (k=0 first) goes to lane k. Weight bit k pairs with lane k.
- `nrn_in_ready` is high in LOAD while fewer than 16 beats are taken. `wgt_ready` is high in LOAD while no weight is held. Both are low in all other states.
- A weight may arrive before, during, or after the neuron beats. LOAD waits for both.
- Vector and weight registers hold their values through FIRE/WAIT and are not cleared between groups.
- Accumulator: cleared on `start`; each WAIT adds sign-extended `pm_final_out`.
- `out_data` = accumulator saturated to signed 16 bits, range [0x8000, 0x7FFF]. It is registered on entry to OUT.
- `start` is ignored outside IDLE, including on the OUT handshake cycle.
- Reset while busy aborts immediately. No partial result is emitted.

## Timing
- Reset values: `nrn_in_ready`, `wgt_ready`, `pm_en`, `out_valid`, `busy` = 0; `pm_input_neuron`, `pm_weight_bits`, `out_data`, accumulator, counters = 0; state IDLE.
- Reference trace (`start` in cycle 0, no stalls, PM_LAT=1):
  - LOAD in cycles 1–16.
  - FIRE (`pm_en`) in cycle 17.
  - WAIT/accumulate in cycle 18.
  - Next LOAD or `out_valid` from cycle 19.
- Throughput: 16+1+PM_LAT cycles per group minimum.
- `group_cnt` = 0: `out_valid` = 1 in cycle 1 with `out_data` = 0, no `pm_en`.
- `out_valid`/`out_data` stay stable until accepted. `busy` drops the cycle after the handshake.

## Structure
- Shared package `nn_pkg`: `LANES`=16, `DATA_W`=16, state enum `pmc_state_t`, signed saturate-to-DATA_W function.
- One sub-module, `nrn_packer`, holds the beat counter and 16x16 lane shift/index register. Its ports are accept, data, clear, full, and vector.

## Test plan
- Packing: neurons 0x0001..0x0010 back-to-back, weight 0xA5A5, `group_cnt`=1 → in cycle 17 `pm_en`=1 for exactly one cycle, `pm_input_neuron[k]`=k+1, `pm_weight_bits`=0xA5A5.
- Accumulate: `group_cnt`=3, bench returns 0x0100, 0xFF00, 0x0005 → `out_data`=0x0005, exactly 3 `pm_en` pulses, first `out_valid` at cycle 55.
- Saturation: 4 groups each returning 0x7000 → 0x7FFF. 4 groups each returning 0x8000 → 0x8000.
- Backpressure:
  - Stimulus: `nrn_in_valid` 50% random; weight given 3 cycles after the 16th beat; `out_ready` low 5 cycles.
  - Response: FIRE only after the weight is captured; lanes correct; `out_valid`/`out_data` stable while stalled; `start` during OUT ignored.
- Zero groups: `group_cnt`=0 → `out_valid` in cycle 1, `out_data`=0x0000, no ready asserted.
- Reset mid-LOAD:
  - Stimulus: `rst` low after 7 beats, then a new `start`.
  - Response: all outputs return to reset values asynchronously; a fresh 16 beats are required and lane 0 receives the first post-reset beat.
